systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Transmit-side edge driver for the output-stationary systolic array of MAC processing elements (PEs).
- Accepts one unskewed reduction step per handshake: one weight per array row and one feature per array column.
- Emits diagonally skewed weight streams into the left edge, feature streams into the top edge, and the per-row clear wavefront marking the first step of a tile.
- Counts the tile's reduction length, drains the array pipeline and pulses done when every PE accumulator holds its final sum.

Parameters:
- ROWS, 4, number of array rows (left-edge weight lanes and clr lanes).
- COLS, 4, number of array columns (top-edge feature lanes).
- K_MAX, 256, maximum reduction length per tile.
- KW, $clog2(K_MAX+1), width of k_len.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  tile start request, sampled only in IDLE
- k_len  in  KW  reduction steps for the tile, latched on accepted start
- busy  out  1  high when state != IDLE
- done  out  1  one-cycle pulse: all PE sums are final
- in_valid  in  1  reduction-step beat valid
- in_ready  out  1  feeder accepts a beat (high in FEED)
- in_weight  in  ROWS*8  signed weights; lane r = bits [8r+7:8r]
- in_feature  in  COLS*8  signed features; lane c = bits [8c+7:8c]
- out_weight  out  ROWS*8  skewed weights to array left edge, row r
- out_feature  out  COLS*8  skewed features to array top edge, column c
- out_clr  out  ROWS  skewed clear to array left edge, row r

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: state IDLE; all skew registers, out_weight, out_feature, out_clr cleared to 0; busy=0, done=0, in_ready=0; step counter and latched k_len cleared. A reset mid-FEED or mid-DRAIN aborts the tile with no done pulse.
- FSM has three states: IDLE, FEED, DRAIN.
- IDLE -> FEED: on start=1 with k_len!=0. k_len is latched and the step counter cleared.
  - start with k_len==0 is ignored.
  - start outside IDLE is ignored.
- FEED: in_ready=1. A beat is accepted when in_valid & in_ready at the rising edge. After the k_len-th accepted beat, go to DRAIN.
- DRAIN lasts exactly ROWS+COLS-1 cycles (down-counter), then returns to IDLE.
- done=1 for exactly the first IDLE cycle after DRAIN. A start in that same cycle is accepted, so back-to-back tiles are allowed.
  - The downstream collector must snapshot the sums within 2 cycles of done, because the next tile's clr overwrites them.
- Skew stage input, per lane:
  - On an accepted beat: lane data.
  - Otherwise (bubble, IDLE, DRAIN): 8'd0.
  - clr input is 1 only on the first accepted beat of a tile (step counter == 0), else 0.
- Skew depth: row r weight and clr pass through r+1 registers; column c feature passes through c+1 registers. Every output is registered.
- Timing: a beat accepted at edge t appears on out_weight row r and out_clr[r] during cycle t+1+r, and on out_feature column c during cycle t+1+c.
  - It therefore meets at PE(r,c) input during cycle t+1+r+c.
  - The bottom-right sum is final from cycle t_last+ROWS+COLS, which is the done cycle.
- Bubbles inject zero products, so accumulations are unaffected and weight/feature alignment is preserved. No downstream backpressure exists; the array consumes every cycle.
- Data is passed unmodified as signed 8-bit; the feeder does no arithmetic.

Test Plan:
- ROWS=COLS=4, k_len=3, in_valid held high, all weights=1, all features=2 -> out_clr[r] pulses exactly once, at cycle s+2+r (start accepted at edge s); done is high exactly at t_last+8; every PE out_sum=6.
- Same tile with in_valid pattern 1,0,0,1,0,1 -> in_ready high throughout FEED; zeros are injected on bubbles; all sums=6; done at t_last+8 after the final accept.
- Signed corner: k_len=2, all weights=-128, all features=-128 -> every sum=32768; row 3 out_weight lags row 0 by exactly 3 cycles.
- start pulsed during FEED/DRAIN, and start with k_len=0 in IDLE -> no state change, no extra done; busy stays consistent.
- rst asserted on the 2nd FEED beat -> next cycle all outputs are 0, busy=0, and no done ever appears. A new start with k_len=1, weight=3, feature=4 -> sums=12.
- start asserted in the done cycle with k_len=1, weight=5, feature=5 -> accepted; first-tile sums are held until the new clr reaches each PE; the new sums are 25.

Source files
------------

// File: rtl/systolic_feeder.sv
// systolic_feeder
//
// Edge driver for an output-stationary systolic MAC array. Each accepted
// handshake carries one unskewed reduction step: one signed 8-bit weight per
// array row and one signed 8-bit feature per array column. The feeder skews
// them diagonally so that row r enters the left edge r cycles late and
// column c enters the top edge c cycles late. The weight and the feature of
// one step therefore meet at PE(r,c). A per-row clear travels with the
// weights and marks the first step of a tile. After the last step the FSM
// drains the array pipeline. It pulses done when the bottom-right
// accumulator holds its final sum.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset; aborts any tile in flight
//   start        tile start request, only looked at in IDLE
//   k_len        reduction steps of the tile, latched on an accepted start
//   busy         high whenever the FSM is not IDLE
//   done         one-cycle pulse: every PE sum is final
//   in_valid     reduction-step beat valid
//   in_ready     feeder can take a beat (high throughout FEED)
//   in_weight    ROWS signed weights, lane r = bits [8r+7:8r]
//   in_feature   COLS signed features, lane c = bits [8c+7:8c]
//   out_weight   skewed weights to the array left edge, row r
//   out_feature  skewed features to the array top edge, column c
//   out_clr      skewed accumulator clear to the array left edge, row r
//   dbg_state    current FSM state (0 IDLE, 1 FEED, 2 DRAIN)
//
// Handshake: a beat transfers on a rising edge where in_valid and in_ready
// are both high. in_ready depends only on the FSM state, never on in_valid,
// so the source may hold in_valid high or drop it for bubbles at will. A
// bubble cycle pushes zeros into the skew lanes. The zeros contribute zero
// products, so bubbles keep the array aligned without disturbing the sums.

module systolic_feeder #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int K_MAX = 256,
  parameter int KW    = $clog2(K_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KW-1:0]     k_len,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ROWS*8-1:0] in_weight,
  input  logic [COLS*8-1:0] in_feature,
  output logic [ROWS*8-1:0] out_weight,
  output logic [COLS*8-1:0] out_feature,
  output logic [ROWS-1:0]   out_clr,
  output logic [1:0]        dbg_state
);

  // The last step enters PE(0,0) one cycle after it is accepted. It reaches
  // PE(ROWS-1,COLS-1) ROWS+COLS-2 cycles later. Its product is in the
  // accumulator one cycle after that. So DRAIN spans ROWS+COLS-1 cycles.
  localparam int DRAIN_LEN = ROWS + COLS - 1;
  localparam int DW        = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   step_cnt;
  logic [KW-1:0]   k_lat;
  logic [DW-1:0]   drain_cnt;
  logic            done_q;
  logic            accept;
  logic            last_beat;
  logic            tile_go;

  // Skew stage inputs: lane data on an accepted beat, zero otherwise.
  logic [ROWS*8-1:0] stage_w;
  logic [COLS*8-1:0] stage_f;
  logic              stage_clr;

  // ---------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    last_beat = 1'b0;
    tile_go   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A start with a zero-length tile has nothing to feed; ignore it.
        if (start && (k_len != '0)) begin
          tile_go = 1'b1;
          state_d = S_FEED;
        end
      end
      S_FEED: begin
        accept = in_valid;
        if (in_valid && ((step_cnt + KW'(1)) == k_lat)) begin
          last_beat = 1'b1;
          state_d   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == '0) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM state, step counter, drain counter, done pulse
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      step_cnt  <= '0;
      k_lat     <= '0;
      drain_cnt <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // done lands on the first IDLE cycle after DRAIN. A start seen in that
      // cycle is honoured, so tiles can run back to back.
      done_q  <= (state_q == S_DRAIN) && (drain_cnt == '0);

      if (tile_go) begin
        k_lat    <= k_len;
        step_cnt <= '0;
      end else if (accept) begin
        step_cnt <= step_cnt + KW'(1);
      end

      if (last_beat) begin
        drain_cnt <= DW'(DRAIN_LEN - 1);
      end else if ((state_q == S_DRAIN) && (drain_cnt != '0)) begin
        drain_cnt <= drain_cnt - DW'(1);
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign in_ready  = (state_q == S_FEED);
  assign done      = done_q;
  assign dbg_state = state_q;

  // ---------------------------------------------------------------------
  // Skew stage inputs
  // ---------------------------------------------------------------------
  always_comb begin
    stage_w   = '0;
    stage_f   = '0;
    stage_clr = 1'b0;
    if (accept) begin
      stage_w   = in_weight;
      stage_f   = in_feature;
      // Only the first step of a tile restarts the accumulators.
      stage_clr = (step_cnt == '0);
    end
  end

  // ---------------------------------------------------------------------
  // Row lanes: row r weight and clear pass through r+1 registers.
  // ---------------------------------------------------------------------
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [7:0] w_sr [0:r];
    logic       c_sr [0:r];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i <= r; i++) begin
          w_sr[i] <= '0;
          c_sr[i] <= 1'b0;
        end
      end else begin
        w_sr[0] <= stage_w[8*r +: 8];
        c_sr[0] <= stage_clr;
        for (int i = 1; i <= r; i++) begin
          w_sr[i] <= w_sr[i-1];
          c_sr[i] <= c_sr[i-1];
        end
      end
    end

    assign out_weight[8*r +: 8] = w_sr[r];
    assign out_clr[r]           = c_sr[r];
  end

  // ---------------------------------------------------------------------
  // Column lanes: column c feature passes through c+1 registers.
  // ---------------------------------------------------------------------
  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [7:0] f_sr [0:c];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i <= c; i++) begin
          f_sr[i] <= '0;
        end
      end else begin
        f_sr[0] <= stage_f[8*c +: 8];
        for (int i = 1; i <= c; i++) begin
          f_sr[i] <= f_sr[i-1];
        end
      end
    end

    assign out_feature[8*c +: 8] = f_sr[c];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Testbench for systolic_feeder. A behavioural 4x4 output-stationary MAC
// array sits on the feeder outputs. When a tile is issued, the driver pushes
// the expected clear-pulse cycles, the expected done cycle and the expected
// PE sum into queues. A monitor running on the falling edge pops and compares
// them whenever out_clr or done is presented.

module tb_systolic_feeder;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int K_MAX = 256;
  localparam int KW    = $clog2(K_MAX + 1);
  localparam int HIST  = 1024;

  logic              clk;
  logic              rst;
  logic              start;
  logic [KW-1:0]     k_len;
  logic              busy;
  logic              done;
  logic              in_valid;
  logic              in_ready;
  logic [ROWS*8-1:0] in_weight;
  logic [COLS*8-1:0] in_feature;
  logic [ROWS*8-1:0] out_weight;
  logic [COLS*8-1:0] out_feature;
  logic [ROWS-1:0]   out_clr;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int          exp_clr_q[$];   // encoded as cycle*16 + row
  int          exp_done_q[$];  // cycle in which done must be seen
  logic [31:0] exp_sum_q[$];   // sum every PE must hold at done

  logic [ROWS*8-1:0] w_hist [0:HIST-1];
  logic [COLS*8-1:0] f_hist [0:HIST-1];

  systolic_feeder #(
    .ROWS (ROWS),
    .COLS (COLS),
    .K_MAX(K_MAX),
    .KW   (KW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .k_len      (k_len),
    .busy       (busy),
    .done       (done),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_weight  (in_weight),
    .in_feature (in_feature),
    .out_weight (out_weight),
    .out_feature(out_feature),
    .out_clr    (out_clr),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------
  // Clock / reset block
  // ---------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index as seen at the falling edge. Inputs driven at the falling
  // edge of cycle n are sampled by the rising edge that ends cycle n.
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Behavioural output-stationary array fed by the DUT.
  // ---------------------------------------------------------------------
  logic signed [7:0]  mw  [ROWS][COLS];
  logic signed [7:0]  mf  [ROWS][COLS];
  logic               mc  [ROWS][COLS];
  logic signed [31:0] acc [ROWS][COLS];
  logic signed [7:0]  m_wi, m_fi;
  logic               m_ci;
  logic signed [31:0] m_prod;

  always @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (c == 0) begin
          m_wi = out_weight[8*r +: 8];
          m_ci = out_clr[r];
        end else begin
          m_wi = mw[r][c-1];
          m_ci = mc[r][c-1];
        end
        if (r == 0) m_fi = out_feature[8*c +: 8];
        else        m_fi = mf[r-1][c];
        m_prod = m_wi * m_fi;
        if (rst) begin
          mw[r][c]  <= '0;
          mf[r][c]  <= '0;
          mc[r][c]  <= 1'b0;
          acc[r][c] <= '0;
        end else begin
          mw[r][c]  <= m_wi;
          mf[r][c]  <= m_fi;
          mc[r][c]  <= m_ci;
          acc[r][c] <= m_ci ? m_prod : acc[r][c] + m_prod;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------
  always @(negedge clk) begin
    if (cyc < HIST) begin
      w_hist[cyc] = out_weight;
      f_hist[cyc] = out_feature;
    end
    for (int r = 0; r < ROWS; r++) begin
      if (out_clr[r]) begin
        checks++;
        if (exp_clr_q.size() == 0) begin
          errors++;
          $display("FAIL clr_unexpected: row %0d pulsed at cycle %0d, none expected", r, cyc);
        end else begin
          int e;
          e = exp_clr_q.pop_front();
          if (e != cyc*16 + r) begin
            errors++;
            $display("FAIL clr_timing: got row %0d cycle %0d, expected row %0d cycle %0d",
                     r, cyc, e % 16, e / 16);
          end
        end
      end
    end
    if (done) begin
      checks++;
      if (exp_done_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: done at cycle %0d, none expected", cyc);
      end else begin
        int          d;
        logic [31:0] es;
        d  = exp_done_q.pop_front();
        es = exp_sum_q.pop_front();
        if (d != cyc) begin
          errors++;
          $display("FAIL done_cycle: got %0d expected %0d", cyc, d);
        end
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) begin
            checks++;
            if (acc[r][c] !== $signed(es)) begin
              errors++;
              $display("FAIL pe_sum(%0d,%0d): got %0d expected %0d", r, c, acc[r][c], $signed(es));
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a falling edge; start is presented in the current cycle s.
  // pat holds the in_valid pattern (bit i for feed cycle i); plen==0 means
  // in_valid held high. poke raises a spurious start on feed cycle 1.
  task automatic run_tile(input int k, input logic signed [7:0] w, input logic signed [7:0] f,
                          input logic [7:0] pat, input int plen, input bit poke,
                          output int s, output int t_last);
    int n;
    int i;
    start      = 1'b1;
    k_len      = KW'(k);
    in_weight  = {ROWS{w}};
    in_feature = {COLS{f}};
    s          = cyc;
    t_last     = 0;
    for (int r = 0; r < ROWS; r++) exp_clr_q.push_back((s + 2 + r) * 16 + r);
    @(negedge clk);
    start = 1'b0;
    k_len = '0;
    n = 0;
    i = 0;
    while (n < k && i < 64) begin
      check("in_ready_feed", int'(in_ready), 1);
      check("busy_feed", int'(busy), 1);
      in_valid = (plen == 0) ? 1'b1 : pat[i % plen];
      if (poke && i == 1) begin
        start = 1'b1;
        k_len = KW'(7);
      end
      if (in_valid) begin
        n++;
        t_last = cyc;
      end
      i++;
      @(negedge clk);
      start = 1'b0;
      k_len = '0;
    end
    in_valid = 1'b0;
    exp_done_q.push_back(t_last + ROWS + COLS);
    exp_sum_q.push_back(32'(k * int'(w) * int'(f)));
  endtask

  // Waits, with a cycle budget, until the monitor has consumed every
  // expected done. poke raises a spurious start during DRAIN.
  task automatic wait_done(input bit poke);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      start = 1'b0;
      k_len = '0;
      if (exp_done_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      check("busy_drain", int'(busy), 1);
      if (poke && i == 1) begin
        start = 1'b1;
        k_len = KW'(7);
      end
    end
    start = 1'b0;
    k_len = '0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within 40 cycles, expected one (cycle %0d)", cyc);
    end else begin
      check("busy_done_cycle", int'(busy), 0);
    end
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    int s, tl, d;
    rst        = 1'b1;
    start      = 1'b0;
    k_len      = '0;
    in_valid   = 1'b0;
    in_weight  = '0;
    in_feature = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_weight", int'(out_weight), 0);
    check("rst_out_feature", int'(out_feature), 0);
    check("rst_out_clr", int'(out_clr), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_state", int'(dbg_state), 0);

    // start with k_len==0 is ignored
    start = 1'b1;
    k_len = '0;
    @(negedge clk);
    start = 1'b0;
    check("k0_busy", int'(busy), 0);
    check("k0_in_ready", int'(in_ready), 0);
    repeat (3) @(negedge clk);
    check("k0_busy_later", int'(busy), 0);

    // Tile A: k=3, valid held high, w=1, f=2 -> sums 6
    run_tile(3, 8'sd1, 8'sd2, 8'h00, 0, 1'b0, s, tl);
    wait_done(1'b0);

    // Tile B: same tile with bubble pattern 1,0,0,1,0,1 and spurious starts
    run_tile(3, 8'sd1, 8'sd2, 8'b0010_1001, 6, 1'b1, s, tl);
    wait_done(1'b1);
    check("bubble_last_beat", tl, s + 6);
    check("bubble_w0_beat1", int'(w_hist[s+2][7:0]), 1);
    check("bubble_w0_zero_a", int'(w_hist[s+3][7:0]), 0);
    check("bubble_w0_zero_b", int'(w_hist[s+4][7:0]), 0);
    check("bubble_w0_beat2", int'(w_hist[s+5][7:0]), 1);
    check("bubble_f3_zero", int'(f_hist[s+6][31:24]), 0);

    // Signed corner: k=2, -128 * -128 -> sums 32768
    run_tile(2, -8'sd128, -8'sd128, 8'h00, 0, 1'b0, s, tl);
    wait_done(1'b0);
    check("signed_w0_first", int'(w_hist[s+2][7:0]), 128);
    check("signed_w3_before", int'(w_hist[s+4][31:24]), 0);
    check("signed_w3_first", int'(w_hist[s+5][31:24]), 128);
    check("signed_f3_first", int'(f_hist[s+5][31:24]), 128);

    // Reset on the second FEED beat aborts the tile with no done
    start      = 1'b1;
    k_len      = KW'(3);
    in_weight  = {ROWS{8'sd7}};
    in_feature = {COLS{8'sd7}};
    s          = cyc;
    exp_clr_q.push_back((s + 2) * 16 + 0);
    @(negedge clk);
    start    = 1'b0;
    k_len    = '0;
    in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_out_weight", int'(out_weight), 0);
    check("abort_out_feature", int'(out_feature), 0);
    check("abort_out_clr", int'(out_clr), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_in_ready", int'(in_ready), 0);
    check("abort_done", int'(done), 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_idle_busy", int'(busy), 0);

    // Fresh tile after the abort: k=1, 3*4 -> 12
    run_tile(1, 8'sd3, 8'sd4, 8'h00, 0, 1'b0, s, tl);
    wait_done(1'b0);

    // Back-to-back: start in the done cycle of a k=3 (1*2) tile, then k=1 5*5
    run_tile(3, 8'sd1, 8'sd2, 8'h00, 0, 1'b0, s, tl);
    d = tl + ROWS + COLS;
    while (cyc < d) @(negedge clk);
    check("b2b_done_seen", int'(done), 1);
    run_tile(1, 8'sd5, 8'sd5, 8'h00, 0, 1'b0, s, tl);
    check("b2b_accept_cycle", s, d);
    wait_done(1'b0);

    repeat (6) @(negedge clk);
    check("clr_queue_drained", exp_clr_q.size(), 0);
    check("done_queue_drained", exp_done_q.size(), 0);
    check("final_busy", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
